// File: rtl/xmit_frame_gen.sv
// Programmable transmit-path frame generator: head/body/tail framing, gap, priority modes
// and discard counting, with every output driven from a register.
module xmit_frame_gen #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       LEN_W     = 12,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] HEAD_BYTE = 8'hFF,
  parameter logic [DATA_W-1:0] BODY_BYTE = 8'h00,
  parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [CNT_W-1:0]     cfg_num,
  input  logic [CNT_W-1:0]     cfg_gap,
  input  logic [1:0]           cfg_prio,
  input  logic                 cfg_incr,
  input  logic                 m_discard_en,
  output logic [DATA_W-1:0]    f_data_in,
  output logic                 f_rec_data_valid,
  output logic                 f_rec_frame_valid,
  output logic [2*LEN_W-1:0]   f_ctrl_in,
  output logic                 f_hi_priority,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     discard_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, num_q, num_d, gap_q, gap_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          prio_q, prio_d;
  logic                incr_q, incr_d, stop_q, stop_d, tog_q, tog_d, done_arm_q, done_arm_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d, fv_q, fv_d, hi_q, hi_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2*LEN_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]    pkt_q, pkt_d, disc_q, disc_d;
  logic                busy_st_s, stop_seen_s, last_pkt_s;

  assign busy_st_s   = (state_q == S_HEAD) || (state_q == S_BODY) || (state_q == S_TAIL) || (state_q == S_GAP);
  assign stop_seen_s = stop_q || stop;
  assign last_pkt_s  = (num_q != CNT_W'(0)) && ((pkt_q + CNT_W'(1)) == num_q);

  // Next-state logic; outputs are derived from the current state, so they trail it by one edge.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; len_d = len_q; num_d = num_q; gap_d = gap_q;
    prio_d = prio_q; incr_d = incr_q; tog_d = tog_q; lfsr_d = lfsr_q; pkt_d = pkt_q;
    data_d = DATA_W'(0); dv_d = 1'b0; fv_d = 1'b0; ctrl_d = (2*LEN_W)'(0); hi_d = hi_q;
    busy_d = busy_st_s; done_d = done_arm_q; err_d = 1'b0;
    if (state_q != S_IDLE && m_discard_en && !(&disc_q)) disc_d = disc_q + CNT_W'(1);
    else disc_d = disc_q;
    if (busy_st_s && stop) stop_d = 1'b1;
    else stop_d = stop_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && (cfg_len < LEN_W'(8))) begin
          err_d = 1'b1;
        end else if (start) begin
          state_d = S_HEAD; cnt_d = CNT_W'(0);
          len_d = cfg_len; num_d = cfg_num; gap_d = cfg_gap; prio_d = cfg_prio; incr_d = cfg_incr;
          stop_d = 1'b0; tog_d = 1'b0; lfsr_d = LFSR_SEED; pkt_d = CNT_W'(0); disc_d = CNT_W'(0);
        end else begin
          state_d = state_q;
        end
      end
      S_HEAD: begin
        data_d = HEAD_BYTE; dv_d = 1'b1;
        if (cnt_q == CNT_W'(0)) begin
          fv_d = 1'b1; ctrl_d = {len_q, len_q};
          case (prio_q)
            2'b00:   hi_d = 1'b0;
            2'b01:   hi_d = 1'b1;
            2'b10:   hi_d = tog_q;
            2'b11:   hi_d = lfsr_q[0];
            default: hi_d = 1'b0;
          endcase
          tog_d = ~tog_q; lfsr_d = lfsr_next(lfsr_q);
        end else begin
          fv_d = 1'b0;
        end
        if (cnt_q == CNT_W'(3)) begin
          cnt_d = CNT_W'(0);
          if (len_q == LEN_W'(8)) state_d = S_TAIL;
          else state_d = S_BODY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BODY: begin
        dv_d = 1'b1;
        if (incr_q) data_d = cnt_q[DATA_W-1:0];
        else data_d = BODY_BYTE;
        if (cnt_q == CNT_W'(len_q - LEN_W'(9))) begin
          state_d = S_TAIL; cnt_d = CNT_W'(0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TAIL: begin
        data_d = HEAD_BYTE; dv_d = 1'b1;
        if (cnt_q == CNT_W'(3)) begin
          cnt_d = CNT_W'(0); pkt_d = pkt_q + CNT_W'(1);
          if (last_pkt_s || stop_seen_s) state_d = S_DONE;
          else if (gap_q != CNT_W'(0)) state_d = S_GAP;
          else state_d = S_HEAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        // A stop seen here ends the run without opening another packet.
        if (cnt_q == (gap_q - CNT_W'(1))) begin
          cnt_d = CNT_W'(0);
          if (stop_seen_s) state_d = S_DONE;
          else state_d = S_HEAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_arm_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state_q <= S_IDLE; cnt_q <= CNT_W'(0); len_q <= LEN_W'(0); num_q <= CNT_W'(0); gap_q <= CNT_W'(0);
      prio_q <= 2'b00; incr_q <= 1'b0; stop_q <= 1'b0; tog_q <= 1'b0; done_arm_q <= 1'b0; lfsr_q <= LFSR_SEED;
      data_q <= DATA_W'(0); dv_q <= 1'b0; fv_q <= 1'b0; ctrl_q <= (2*LEN_W)'(0); hi_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; pkt_q <= CNT_W'(0); disc_q <= CNT_W'(0);
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; len_q <= len_d; num_q <= num_d; gap_q <= gap_d;
      prio_q <= prio_d; incr_q <= incr_d; stop_q <= stop_d; tog_q <= tog_d; done_arm_q <= done_arm_d; lfsr_q <= lfsr_d;
      data_q <= data_d; dv_q <= dv_d; fv_q <= fv_d; ctrl_q <= ctrl_d; hi_q <= hi_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d; pkt_q <= pkt_d; disc_q <= disc_d;
    end
  end

  assign f_data_in         = data_q;
  assign f_rec_data_valid  = dv_q;
  assign f_rec_frame_valid = fv_q;
  assign f_ctrl_in         = ctrl_q;
  assign f_hi_priority     = hi_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign cfg_err           = err_q;
  assign pkt_count         = pkt_q;
  assign discard_count     = disc_q;

endmodule

// File: tb/tb_xmit_frame_gen.sv
// Self-checking bench for xmit_frame_gen: table-driven runs plus random configurations,
// checked cycle by cycle against a packet-level reference stream.
module tb_xmit_frame_gen;
  logic        clk_sys = 1'b0;
  logic        reset, start, stop, cfg_incr, m_discard_en;
  logic [11:0] cfg_len;
  logic [15:0] cfg_num, cfg_gap, pkt_count, discard_count;
  logic [1:0]  cfg_prio;
  logic [7:0]  f_data_in;
  logic        f_rec_data_valid, f_rec_frame_valid, f_hi_priority, busy, done, cfg_err;
  logic [23:0] f_ctrl_in;

  always #5 clk_sys = ~clk_sys;

  xmit_frame_gen dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .stop(stop), .cfg_len(cfg_len),
    .cfg_num(cfg_num), .cfg_gap(cfg_gap), .cfg_prio(cfg_prio), .cfg_incr(cfg_incr),
    .m_discard_en(m_discard_en), .f_data_in(f_data_in), .f_rec_data_valid(f_rec_data_valid),
    .f_rec_frame_valid(f_rec_frame_valid), .f_ctrl_in(f_ctrl_in), .f_hi_priority(f_hi_priority),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pkt_count(pkt_count), .discard_count(discard_count)
  );

  typedef struct { logic [7:0] data; logic dv; logic fv; logic [23:0] ctrl; logic hi; } beat_t;
  typedef struct { int len; int num; int gap; int prio; int incr; int stop_pkt; int disc; int busy_start; int exp_pkt; } vec_t;

  int    tests = 0;
  int    fails = 0;
  beat_t expq[$];
  vec_t  vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic [7:0] m;
    m = l & 8'hB8;
    return {l[6:0], 1'($countones(m) % 2)};
  endfunction

  function automatic logic prio_of(input int mode, input int p);
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < p; k++) l = lfsr_step(l);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'(p % 2);
      default: return l[0];
    endcase
  endfunction

  // Expected output stream for one run, one entry per cycle from the first head byte.
  task automatic build(input vec_t v);
    int    npk;
    beat_t b;
    expq.delete();
    npk = (v.stop_pkt != 0) ? v.stop_pkt : v.num;
    for (int p = 0; p < npk; p++) begin
      b.hi = prio_of(v.prio, p);
      for (int c = 0; c < v.len; c++) begin
        b.dv = 1'b1;
        b.fv = (c == 0);
        b.ctrl = (c == 0) ? {12'(v.len), 12'(v.len)} : 24'h0;
        if (c < 4 || c >= v.len - 4) b.data = 8'hFF;
        else b.data = (v.incr != 0) ? 8'((c - 4) % 256) : 8'h00;
        expq.push_back(b);
      end
      if (p < npk - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          b.dv = 1'b0; b.fv = 1'b0; b.ctrl = 24'h0; b.data = 8'h00;
          expq.push_back(b);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int    stop_idx, bs_idx, ndisc, errs, first;
    logic  d;
    build(v);
    stop_idx = (v.stop_pkt != 0) ? (v.stop_pkt - 1) * (v.len + v.gap) + 4 + (v.len - 8) / 2 : -1;
    bs_idx   = (v.busy_start != 0) ? 5 : -1;
    ndisc = 0; errs = 0; first = -1;
    @(posedge clk_sys); #1;
    cfg_len = 12'(v.len); cfg_num = 16'(v.num); cfg_gap = 16'(v.gap);
    cfg_prio = 2'(v.prio); cfg_incr = 1'(v.incr); start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      @(posedge clk_sys); #1;
      if (f_data_in !== expq[i].data || f_rec_data_valid !== expq[i].dv || f_rec_frame_valid !== expq[i].fv ||
          f_ctrl_in !== expq[i].ctrl || f_hi_priority !== expq[i].hi || busy !== 1'b1 || cfg_err !== 1'b0 ||
          done !== 1'b0) begin
        errs++;
        if (first < 0) first = i;
      end
      stop  = (i == stop_idx);
      start = (i == bs_idx);
      if (i == bs_idx) cfg_len = 12'd7;
      d = 1'b0;
      if (i < expq.size() - 1) begin
        if (v.disc > 0) d = (i >= 3 && i < 3 + v.disc);
        else if (v.disc < 0) d = ($urandom_range(0, 3) == 0);
        else d = 1'b0;
      end
      m_discard_en = d;
      if (d) ndisc++;
    end
    m_discard_en = 1'b0; stop = 1'b0; start = 1'b0;
    chk($sformatf("%s stream mismatching cycles (first at %0d)", tag, first), 64'(errs), 64'd0);
    @(posedge clk_sys); #1;
    chk({tag, " done pulse"}, 64'(done), 64'd1);
    chk({tag, " busy low"}, 64'(busy), 64'd0);
    chk({tag, " valid low"}, 64'(f_rec_data_valid), 64'd0);
    chk({tag, " pkt_count"}, 64'(pkt_count), 64'(v.exp_pkt));
    chk({tag, " discard_count"}, 64'(discard_count), 64'(ndisc));
    @(posedge clk_sys); #1;
    chk({tag, " done single"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t r;
    int   bad;
    vecs[0] = '{512, 64, 0, 0, 0, 0, 0, 0, 64};
    vecs[1] = '{8, 3, 2, 2, 0, 0, 0, 0, 3};
    vecs[2] = '{300, 1, 0, 0, 1, 0, 0, 0, 1};
    vecs[3] = '{40, 0, 1, 1, 0, 5, 0, 1, 5};
    vecs[4] = '{20, 6, 1, 3, 0, 0, 10, 0, 6};

    reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_len = 12'd0; cfg_num = 16'd0; cfg_gap = 16'd0;
    cfg_prio = 2'b00; cfg_incr = 1'b0; m_discard_en = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset data", 64'(f_data_in), 64'd0);
    chk("reset dv", 64'(f_rec_data_valid), 64'd0);
    chk("reset fv", 64'(f_rec_frame_valid), 64'd0);
    chk("reset ctrl", 64'(f_ctrl_in), 64'd0);
    chk("reset hi", 64'(f_hi_priority), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset cfg_err", 64'(cfg_err), 64'd0);
    chk("reset pkt_count", 64'(pkt_count), 64'd0);
    chk("reset discard_count", 64'(discard_count), 64'd0);
    m_discard_en = 1'b0; reset = 1'b1;

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      r.len = $urandom_range(8, 40); r.num = $urandom_range(1, 4); r.gap = $urandom_range(0, 3);
      r.prio = $urandom_range(0, 3); r.incr = $urandom_range(0, 1); r.stop_pkt = 0;
      r.disc = -1; r.busy_start = 0; r.exp_pkt = r.num;
      run_vec(r, $sformatf("rand%0d len%0d num%0d gap%0d prio%0d", k, r.len, r.num, r.gap, r.prio));
    end

    // Rejected start: short length pulses cfg_err and nothing leaves the block.
    @(posedge clk_sys); #1;
    cfg_len = 12'd7; cfg_num = 16'd1; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    chk("len7 cfg_err pulse", 64'(cfg_err), 64'd1);
    chk("len7 busy", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_sys); #1;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || f_rec_data_valid !== 1'b0 || f_rec_frame_valid !== 1'b0) bad++;
    end
    chk("len7 stays idle", 64'(bad), 64'd0);

    // Reset during the tail of a packet clears every output at the next edge.
    @(posedge clk_sys); #1;
    cfg_len = 12'd16; cfg_num = 16'd2; cfg_gap = 16'd0; cfg_prio = 2'b01; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk_sys); #1;
    end
    chk("pre-reset tail valid", 64'(f_rec_data_valid), 64'd1);
    chk("pre-reset tail data", 64'(f_data_in), 64'hFF);
    reset = 1'b0; m_discard_en = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b1; m_discard_en = 1'b0;
    chk("tail reset dv", 64'(f_rec_data_valid), 64'd0);
    chk("tail reset data", 64'(f_data_in), 64'd0);
    chk("tail reset hi", 64'(f_hi_priority), 64'd0);
    chk("tail reset busy", 64'(busy), 64'd0);
    chk("tail reset pkt_count", 64'(pkt_count), 64'd0);
    chk("tail reset discard_count", 64'(discard_count), 64'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); #1;
      if (busy !== 1'b0 || f_rec_data_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("after reset idle", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
